// File: rtl/adc_serial_reader.sv
// adc_serial_reader: 16-bit framed serial ADC reader; `define ADC_ZERO_CHECK_EN to flag non-zero leading bits on err
module adc_serial_reader #(
  parameter int DIV_COUNT = 15624,
  parameter int DATA_BITS = 12
) (
  input  logic                 Clck_in,
  input  logic                 reset_Clock_n,
  input  logic                 start,
  input  logic                 sdata,
  output logic                 cs_n,
  output logic                 sclk,
  output logic                 busy,
  output logic [DATA_BITS-1:0] sample,
  output logic                 data_valid,
  output logic                 err
);
  typedef enum logic [1:0] {IDLE, CS_SETUP, SHIFT, QUIET} state_t;
  localparam logic [13:0] DIV = 14'(DIV_COUNT);
  state_t state, state_nxt;
  logic [13:0] div_cnt;
  logic tick, rise, last;
  logic [15:0] shift, shift_nxt;
  logic [4:0] bit_cnt;
  assign rise = tick && state == SHIFT && !sclk;
  assign last = rise && bit_cnt == 5'd15;
  assign shift_nxt = {shift[14:0], sdata};
  always_ff @(posedge Clck_in or negedge reset_Clock_n)
    if (!reset_Clock_n) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state == IDLE     ? (start ? CS_SETUP : IDLE) :
                state == CS_SETUP ? (tick ? SHIFT : CS_SETUP) :
                state == SHIFT    ? (last ? QUIET : SHIFT) :
                                    (tick ? IDLE : QUIET);
  end
  always_comb begin
    cs_n = !(state == CS_SETUP || state == SHIFT);
    busy = state != IDLE;
  end
  // tick is registered, so the FSM acts one cycle after the divider reaches DIV_COUNT
  always_ff @(posedge Clck_in or negedge reset_Clock_n)
    if (!reset_Clock_n) begin
      div_cnt    <= '0;
      tick       <= 1'b0;
      sclk       <= 1'b1;
      bit_cnt    <= '0;
      shift      <= '0;
      sample     <= '0;
      data_valid <= 1'b0;
    end else begin
      div_cnt    <= (state == IDLE || div_cnt == DIV) ? '0 : div_cnt + 14'd1;
      tick       <= state != IDLE && div_cnt == DIV;
      sclk       <= (state == CS_SETUP && tick) ? 1'b0 :
                    (state == SHIFT && tick) ? ~sclk :
                    state == IDLE ? 1'b1 : sclk;
      bit_cnt    <= state == IDLE ? '0 : rise ? bit_cnt + 5'd1 : bit_cnt;
      shift      <= rise ? shift_nxt : shift;
      sample     <= last ? shift_nxt[DATA_BITS-1:0] : sample;
      data_valid <= last;
    end
`ifdef ADC_ZERO_CHECK_EN
  always_ff @(posedge Clck_in or negedge reset_Clock_n)
    if (!reset_Clock_n) err <= 1'b0;
    else if (last) err <= |shift_nxt[15:DATA_BITS];
`else
  assign err = 1'b0;
`endif
endmodule
